// File: rtl/arm32_exec_ctrl.sv
// arm32_exec_ctrl: multi-cycle fetch/decode/execute sequencer for the ARM32 core.
// One instruction in flight; handshaked single-port RAM access for fetch and load/store.
module arm32_exec_ctrl #(
    parameter int                 ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    input  logic              cond_pass,
    input  logic [ADDR_W-1:0] ls_addr,
    output logic [31:0]       ins,
    output logic [ADDR_W-1:0] pc,
    output logic              alu_en,
    output logic              rf_we,
    output logic              flags_we,
    output logic              retire,
    output logic              trap,
    output logic [31:0]       retired_cnt
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              ins_load;
    logic              req_c;
    logic              we_c;
    logic              alu_c;
    logic              rf_c;
    logic              fl_c;
    logic              ret_c;

    logic        is_dp;
    logic        is_ls;
    logic        is_br;
    logic [31:0] br_off;

    assign is_dp  = (ins[27:25] == 3'b001);
    assign is_ls  = (ins[27:25] == 3'b010);
    assign is_br  = (ins[27:25] == 3'b101);
    assign br_off = {{8{ins[23]}}, ins[23:0]};

    // State, PC, instruction register and retire counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            ins         <= '0;
            retired_cnt <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (ins_load) begin
                ins <= mem_rdata;
            end
            if (ret_c) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
        end
    end

    // Next-state, PC update and per-state strobe decode.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ins_load  = 1'b0;
        req_c     = 1'b0;
        we_c      = 1'b0;
        mem_addr  = pc;
        alu_c     = 1'b0;
        rf_c      = 1'b0;
        fl_c      = 1'b0;
        ret_c     = 1'b0;
        unique case (state)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ins_load  = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ins[31:28] == 4'hF) begin
                    state_nxt = S_TRAP;
                end else if (!cond_pass) begin
                    ret_c     = 1'b1;
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = S_FETCH;
                end else if (is_dp || is_ls || is_br) begin
                    state_nxt = S_EXEC;
                end else begin
                    state_nxt = S_TRAP;
                end
            end
            S_EXEC: begin
                alu_c = 1'b1;
                if (is_dp) begin
                    state_nxt = S_WB;
                end else if (is_ls) begin
                    state_nxt = S_MEM;
                end else begin
                    pc_nxt    = pc + ADDR_W'(2) + br_off[ADDR_W-1:0];
                    ret_c     = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                req_c    = 1'b1;
                we_c     = ~ins[20];
                mem_addr = ls_addr;
                if (mem_ready) begin
                    if (ins[20]) begin
                        state_nxt = S_WB;
                    end else begin
                        ret_c     = 1'b1;
                        pc_nxt    = pc + ADDR_W'(1);
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_c      = !(is_dp && (ins[24:23] == 2'b10));
                fl_c      = is_dp && ins[20];
                ret_c     = 1'b1;
                pc_nxt    = pc + ADDR_W'(1);
                state_nxt = S_FETCH;
            end
            S_TRAP: begin
                state_nxt = S_TRAP;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Strobes are forced low for as long as reset is asserted.
    always_comb begin
        mem_req  = req_c & reset_n;
        mem_we   = we_c & req_c & reset_n;
        alu_en   = alu_c & reset_n;
        rf_we    = rf_c & reset_n;
        flags_we = fl_c & reset_n;
        retire   = ret_c & reset_n;
        trap     = (state == S_TRAP);
    end

endmodule

// File: tb/tb_arm32_exec_ctrl.sv
// tb_arm32_exec_ctrl: randomized instruction stream against a transaction-level model.
// Each instruction is predicted as a whole: latency, strobe counts, next PC.
module tb_arm32_exec_ctrl;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic          mem_ready = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic          cond_pass = 1'b1;
    logic [AW-1:0] ls_addr = '0;
    logic [31:0]   ins;
    logic [AW-1:0] pc;
    logic          alu_en;
    logic          rf_we;
    logic          flags_we;
    logic          retire;
    logic          trap;
    logic [31:0]   retired_cnt;

    arm32_exec_ctrl #(.ADDR_W(AW), .RESET_PC('0)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .cond_pass(cond_pass), .ls_addr(ls_addr),
        .ins(ins), .pc(pc), .alu_en(alu_en), .rf_we(rf_we),
        .flags_we(flags_we), .retire(retire), .trap(trap),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0]   ram [0:(1<<AW)-1];
    logic [AW-1:0] pc_m;
    logic [31:0]   ret_m;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_strobes",
            32'({mem_req, mem_we, alu_en, rf_we, flags_we, retire}), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_cnt", retired_cnt, 32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("rst_fetch_req", 32'(mem_req), 32'd1);
        chk("rst_fetch_addr", 32'(mem_addr), 32'd0);
        @(posedge clk);
        pc_m  = '0;
        ret_m = '0;
    endtask

    task automatic drive(input logic rdy);
        @(negedge clk);
        cond_pass = 1'b1;
        mem_ready = rdy;
        mem_rdata = ram[mem_addr];
        #1;
    endtask

    task automatic run_instr(input logic [31:0] w, input logic cp,
                             input int fw, input int mw);
        logic [2:0]    cls;
        logic [AW-1:0] lsa;
        logic [AW-1:0] pc_exp;
        logic [31:0]   off;
        int e_cyc, e_alu, e_rf, e_fl, e_we;
        int cyc, n_alu, n_rf, n_fl, n_we, badaddr, acc, waited, tgt;
        bit done;
        cls    = w[27:25];
        lsa    = AW'($urandom);
        off    = {{8{w[23]}}, w[23:0]};
        pc_exp = pc_m + AW'(1);
        e_alu  = cp ? 1 : 0;
        e_rf   = 0;
        e_fl   = 0;
        e_we   = 0;
        if (!cp) begin
            e_cyc = 2 + fw;
        end else if (cls == 3'b001) begin
            e_cyc = 4 + fw;
            e_rf  = (w[24:23] == 2'b10) ? 0 : 1;
            e_fl  = w[20] ? 1 : 0;
        end else if (cls == 3'b101) begin
            e_cyc  = 3 + fw;
            pc_exp = AW'(int'(pc_m) + 2 + int'(off));
        end else if (w[20]) begin
            e_cyc = 5 + fw + mw;
            e_rf  = 1;
        end else begin
            e_cyc = 4 + fw + mw;
            e_we  = mw + 1;
        end
        ram[pc_m] = w;
        cyc = 0; n_alu = 0; n_rf = 0; n_fl = 0; n_we = 0;
        badaddr = 0; acc = 0; waited = 0; done = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cond_pass = cp;
            ls_addr   = lsa;
            if (mem_req) begin
                tgt = (acc == 0) ? fw : mw;
                if (waited < tgt) begin
                    mem_ready = 1'b0;
                    waited++;
                end else begin
                    mem_ready = 1'b1;
                end
                if (mem_addr !== ((acc == 0) ? pc_m : lsa)) badaddr++;
                mem_rdata = ram[mem_addr];
            end else begin
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
            end
            #1;
            cyc++;
            n_alu += int'(alu_en);
            n_rf  += int'(rf_we);
            n_fl  += int'(flags_we);
            if (mem_req && mem_we) n_we++;
            if (mem_req && mem_ready) begin
                acc++;
                waited = 0;
            end
            if (retire) done = 1;
        end
        chk("retired", 32'(done), 32'd1);
        chk("cycles", 32'(cyc), 32'(e_cyc));
        chk("alu_en", 32'(n_alu), 32'(e_alu));
        chk("rf_we", 32'(n_rf), 32'(e_rf));
        chk("flags_we", 32'(n_fl), 32'(e_fl));
        chk("mem_we", 32'(n_we), 32'(e_we));
        chk("mem_addr", 32'(badaddr), 32'd0);
        pc_m  = pc_exp;
        ret_m = ret_m + 32'd1;
        @(posedge clk);
        #1;
        chk("pc", 32'(pc), 32'(pc_m));
        chk("retired_cnt", retired_cnt, ret_m);
        chk("ins", ins, w);
    endtask

    logic [31:0] d_w  [8] = '{32'hE2811005, 32'hE3510000, 32'h02811005,
                              32'hE5912004, 32'hE5812004, 32'hEAFFFFFE,
                              32'hEA000FF8, 32'hEA000000};
    logic        d_cp [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int          d_mw [8] = '{0, 0, 0, 3, 0, 0, 0, 0};

    initial begin
        logic [31:0] w;
        logic        cp;
        int          k;
        int          act;
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        pc_m  = '0;
        ret_m = '0;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            run_instr(d_w[i], d_cp[i], 0, d_mw[i]);
        end

        for (int i = 0; i < 200; i++) begin
            k  = int'($urandom_range(0, 5));
            w  = $urandom;
            w[31:28] = 4'($urandom_range(0, 14));
            cp = 1'b1;
            case (k)
                0: w[27:25] = 3'b001;
                1: begin w[27:25] = 3'b001; w[24:23] = 2'b10; end
                2: begin w[27:25] = 3'b010; w[20] = 1'b1; end
                3: begin w[27:25] = 3'b010; w[20] = 1'b0; end
                4: w[27:25] = 3'b101;
                default: begin w[27:25] = 3'b001; cp = 1'b0; end
            endcase
            run_instr(w, cp, int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)));
        end

        ram[pc_m] = 32'hE6000010;
        drive(1'b1);
        drive(1'b0);
        chk("trap_decode", 32'(trap), 32'd0);
        act = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom));
            if (i == 0) chk("trap_set", 32'(trap), 32'd1);
            if (mem_req || alu_en || rf_we || flags_we || retire) act++;
            if (pc !== pc_m) act++;
        end
        chk("trap_quiet", 32'(act), 32'd0);
        chk("trap_sticky", 32'(trap), 32'd1);
        chk("trap_ins", ins, 32'hE6000010);
        do_reset();

        ram[0]  = 32'hE5912004;
        ls_addr = AW'(12'h040);
        drive(1'b1);
        drive(1'b0);
        drive(1'b0);
        drive(1'b0);
        chk("mem_pend_req", 32'(mem_req), 32'd1);
        chk("mem_pend_addr", 32'(mem_addr), 32'h040);
        chk("mem_pend_we", 32'(mem_we), 32'd0);
        do_reset();
        run_instr(32'hE2811005, 1'b1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arm32_exec_ctrl.md
Name: arm32_exec_ctrl

Overview:
Multi-cycle sequencing controller for the ARM32 core. It fetches each instruction from the shared single-port RAM and latches it. It then drives the ALU, register-file and flag write strobes per instruction class, runs the load/store memory phase, and updates the PC. It replaces the free-running one-hot step counter in the processor with a handshaked FSM.

Parameters:
ADDR_W, 12, word-address width of the RAM port and PC (PC counts words).
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock.
reset_n  in  1  synchronous, active-low reset.
mem_req  out  1  RAM access request; held until mem_ready.
mem_we  out  1  RAM write enable; valid with mem_req.
mem_addr  out  ADDR_W  RAM word address; stable while mem_req=1.
mem_ready  in  1  RAM completes the access in the cycle it is sampled high with mem_req=1.
mem_rdata  in  32  RAM read data; valid when mem_ready=1.
cond_pass  in  1  condition-unit result for ins[31:28] against the current flags.
ls_addr  in  ADDR_W  effective load/store word address from the datapath; valid in MEM.
ins  out  32  latched instruction register.
pc  out  ADDR_W  current instruction word address.
alu_en  out  1  one-cycle ALU/address-calculation strobe.
rf_we  out  1  register-file write strobe (rd/rt).
flags_we  out  1  CPSR NZCV write strobe.
retire  out  1  one-cycle pulse per completed or skipped instruction.
trap  out  1  sticky undefined-instruction indicator.
retired_cnt  out  32  count of retire pulses.

Behaviour:
- Reset (reset_n=0 at a clk edge) produces the following values:
  - state=FETCH, pc=RESET_PC, ins=0, trap=0, retired_cnt=0.
  - All strobes (mem_req, mem_we, alu_en, rf_we, flags_we, retire) are 0 while reset_n=0.
  - Reset aborts any state, including a pending memory access. mem_req is 0 in the first cycle that reset_n is low.
- Strobes are Moore decodes of the state, with no combinational path from mem_ready to mem_req.
- States and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready=1, ins<=mem_rdata and go to DECODE; otherwise stay.
  - DECODE: evaluated in this order.
    - ins[31:28]=1111 -> TRAP.
    - cond_pass=0 -> retire, pc<=pc+1, go to FETCH.
    - ins[27:25]=001 (data-processing immediate), 010 (load/store immediate) or 101 (branch) -> EXEC.
    - Any other class -> TRAP.
  - EXEC: alu_en=1 for exactly one cycle.
    - Data-processing -> WB.
    - Load/store -> MEM.
    - Branch: pc<=pc+2+sign_extend(ins[23:0]) truncated to ADDR_W, retire, go to FETCH.
  - MEM: mem_req=1, mem_addr=ls_addr, mem_we=~ins[20]. Stay until mem_ready=1.
    - Load (ins[20]=1) -> WB; the datapath captures mem_rdata in that cycle.
    - Store -> retire, pc<=pc+1, go to FETCH.
  - WB:
    - rf_we=1, except for data-processing with ins[24:23]=10 (TST/TEQ/CMP/CMN), which gives rf_we=0.
    - flags_we=ins[20] for data-processing; flags_we=0 for loads.
    - retire, pc<=pc+1, go to FETCH.
  - TRAP: trap=1. All strobes are 0; pc and ins are frozen. Only reset exits this state.
- Latency with a zero-wait RAM:
  - Data-processing: 4 cycles.
  - Condition-failed instruction: 2 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Branch: 3 cycles.
  - Each wait cycle adds one cycle.
- PC arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- retired_cnt increments on every retire and wraps at 2^32.
- retire and a strobe never coincide across different instructions; at most one instruction is in flight.
- mem_ready while mem_req=0 is ignored.

Test Plan:
1. pc=0, RAM[0]=0xE2811005 (ADD r1,r1,#5), zero-wait, cond_pass=1 -> FETCH, DECODE, EXEC (alu_en=1), WB (rf_we=1, flags_we=0, retire=1); pc=1 and retired_cnt=1 at cycle 4.
2. CMP 0xE3510000 -> WB gives rf_we=0, flags_we=1. Same ADD encoding with cond 0x0 and cond_pass=0 -> no alu_en; retire in DECODE; pc+1 after 2 cycles.
3. LDR 0xE5912004, ls_addr=0x040, mem_ready low for 3 MEM cycles -> mem_req=1, mem_we=0 and mem_addr=0x040 held 4 cycles, then WB with rf_we=1. STR 0xE5812004 -> mem_we=1, no rf_we, retire at the MEM handshake.
4. Branches:
   - pc=5, 0xEAFFFFFE -> pc=5 after 3 cycles.
   - pc=4095 (ADDR_W=12), 0xEA000000 -> pc=1 (wrap).
5. Undefined 0xE6000010 -> trap=1 from the cycle after DECODE. mem_req stays 0 and pc is frozen for 20 cycles; reset_n=0 then returns trap=0 and pc=0.
6. reset_n pulsed low while in MEM with mem_req=1 -> mem_req=0 and state=FETCH at the next edge; pc=RESET_PC; no rf_we or retire is emitted for the aborted instruction.
